frame_rd_sched: RTL
===================

# frame_rd_sched

Read-side scheduler between the frame buffer memory controller and the display line FIFO that feeds the HDMI pixel path. Tracks free FIFO space and issues fixed-length burst read commands, one at a time, walking linearly through the active frame (default 1024x768 RGB565 words). Restarts at each display frame start. Optionally ping-pongs between two frame buffers so the display never reads a frame the camera writer is still filling.

## Interface
Parameters:
- H_ACT, 1024, active pixels per line (one 16-bit word each)
- V_ACT, 768, active lines per frame
- BURST_LEN, 64, words per read command; must divide H_ACT*V_ACT
- FIFO_DEPTH, 1024, display FIFO capacity in words
- ADDR_W, 24, word address width
- FB_BASE0, 24'h000000, word base address of buffer 0
- FB_BASE1, 24'h0C0000, word base address of buffer 1

Ports:
- pixel_clk  in  1  single clock for all logic
- sys_rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at display vertical blank start
- wr_frame_done  in  1  one-cycle pulse: writer finished a frame into the non-displayed buffer
- fifo_level  in  11  current display FIFO word count
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  controller accepts the command when valid&&ready
- rd_cmd_addr  out  ADDR_W  burst start word address
- rd_cmd_len  out  8  burst length, always BURST_LEN
- rd_data_valid  in  1  one returned word this cycle (also pushed into the FIFO)
- disp_buf_sel  out  1  buffer currently being read
- frame_active  out  1  high while the current frame still has bursts to issue or return
- ovf_err  out  1  sticky: a rd_data_valid arrived outside WAIT_DATA; cleared only by reset

## Operation
- FSM states: IDLE, WAIT_SPACE, ISSUE, WAIT_DATA.
- IDLE: on frame_start, latch the buffer base, set burst_idx=0, and go to WAIT_SPACE.
- WAIT_SPACE: go to ISSUE when fifo_level + BURST_LEN <= FIFO_DEPTH. Compute the sum in 12 bits; no wrap.
- ISSUE: assert rd_cmd_valid with rd_cmd_addr = base + burst_idx*BURST_LEN. Hold addr and len stable until the handshake completes. On handshake, go to WAIT_DATA and clear the return counter.
- WAIT_DATA: count rd_data_valid. When the count reaches BURST_LEN, increment burst_idx. If burst_idx was the last one (H_ACT*V_ACT/BURST_LEN - 1), go to IDLE; otherwise go to WAIT_SPACE.
- Only one outstanding burst at a time.
- frame_start while not IDLE: set restart_pend.
  - In WAIT_SPACE, restart immediately (burst_idx=0, base relatched); stay in WAIT_SPACE.
  - In ISSUE, complete the pending handshake first; a command already presented is never withdrawn.
  - In WAIT_DATA, finish the burst, then restart instead of advancing.
- Buffer selection: wr_frame_done sets new_frame_rdy. At frame_start, if new_frame_rdy is set, toggle disp_buf_sel and clear new_frame_rdy. The base is taken from the new selection. Otherwise keep the old buffer (repeat frame). If wr_frame_done and frame_start occur in the same cycle, the swap happens on that frame_start.
- frame_active = (state != IDLE).

## Timing
- Reset values: rd_cmd_valid=0, rd_cmd_addr=0, rd_cmd_len=BURST_LEN, disp_buf_sel=0, frame_active=0, ovf_err=0; state IDLE; all counters and flags cleared.
- frame_start to rd_cmd_valid: 2 cycles when the FIFO has space (IDLE->WAIT_SPACE->ISSUE). All outputs are registered.
- Last returned word to the next rd_cmd_valid: 2 cycles when space is available.
- sys_rst mid-burst: the FSM returns to IDLE immediately. Any late rd_data_valid sets ovf_err; the integrator must reset the controller together with this block.

## Configuration
- FRAME_PINGPONG_EN defined: two buffers, swap logic as above.
- FRAME_PINGPONG_EN undefined:
  - base is always FB_BASE0 and disp_buf_sel is tied to 0.
  - wr_frame_done is ignored and new_frame_rdy is not built.

## Structure
- Shared package frame_rd_pkg: FSM state enum, BURST_LEN/H_ACT/V_ACT defaults, derived constant BURSTS_PER_FRAME.
- One natural sub-module: frame_buf_sel, containing the new_frame_rdy flag and disp_buf_sel toggle. It is compiled away when FRAME_PINGPONG_EN is off.

## Test plan
- Reset, fifo_level=0, frame_start -> rd_cmd_valid 2 cycles later, addr=0x000000, len=64. With ready held high, second command addr=0x000040 two cycles after the 64th data word.
- fifo_level=961 held -> no command. Drop it to 960 -> command issued.
- Full frame with immediate ready/data -> exactly 12288 commands. Last addr=0x0BFFC0, then frame_active falls.
- frame_start during WAIT_DATA at burst 5 -> burst completes, next addr = base+0.
- With FRAME_PINGPONG_EN: wr_frame_done then frame_start -> disp_buf_sel=1, first addr=0x0C0000. A frame_start with no new wr_frame_done -> stays on buffer 1.
- rd_data_valid pulsed while IDLE -> ovf_err=1, held until sys_rst.

Source files
------------

// File: rtl/frame_rd_pkg.sv
// Shared types and default geometry for the frame buffer read scheduler.
package frame_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        ISSUE,
        WAIT_DATA
    } state_t;

    localparam int unsigned DEF_H_ACT     = 1024;
    localparam int unsigned DEF_V_ACT     = 768;
    localparam int unsigned DEF_BURST_LEN = 64;

    function automatic int unsigned bursts_per_frame(input int unsigned h, input int unsigned v,
                                                     input int unsigned b);
        return (h * v) / b;
    endfunction

    localparam int unsigned BURSTS_PER_FRAME = bursts_per_frame(DEF_H_ACT, DEF_V_ACT, DEF_BURST_LEN);

endpackage

// File: rtl/frame_buf_sel.sv
// Ping-pong display buffer selection: remembers a finished writer frame and
// swaps the displayed buffer at the next display frame start.
module frame_buf_sel (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic wr_frame_done,
    output logic next_sel,
    output logic disp_buf_sel
);

    logic new_frame_rdy;

    // A writer completion coinciding with frame_start still swaps on that frame.
    assign next_sel = (frame_start && (new_frame_rdy || wr_frame_done)) ? ~disp_buf_sel : disp_buf_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_buf_sel  <= 1'b0;
            new_frame_rdy <= 1'b0;
        end else begin
            disp_buf_sel <= next_sel;
            if (frame_start) begin
                new_frame_rdy <= 1'b0;
            end else if (wr_frame_done) begin
                new_frame_rdy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_rd_sched.sv
// Burst read scheduler from the frame buffer into the display line FIFO.
// Define FRAME_PINGPONG_EN to alternate between FB_BASE0 and FB_BASE1.
module frame_rd_sched
    import frame_rd_pkg::*;
#(
    parameter int unsigned          H_ACT      = DEF_H_ACT,
    parameter int unsigned          V_ACT      = DEF_V_ACT,
    parameter int unsigned          BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned          FIFO_DEPTH = 1024,
    parameter int unsigned          ADDR_W     = 24,
    parameter logic [ADDR_W-1:0]    FB_BASE0   = 24'h000000,
    parameter logic [ADDR_W-1:0]    FB_BASE1   = 24'h0C0000
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,
    input  logic              frame_start,
    input  logic              wr_frame_done,
    input  logic [10:0]       fifo_level,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [7:0]        rd_cmd_len,
    input  logic              rd_data_valid,
    output logic              disp_buf_sel,
    output logic              frame_active,
    output logic              ovf_err
);

    localparam int unsigned N_BURSTS = bursts_per_frame(H_ACT, V_ACT, BURST_LEN);
    localparam int unsigned BIDX_W   = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
    localparam int unsigned RET_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t              state;
    logic [BIDX_W-1:0]   burst_idx;
    logic [RET_W-1:0]    ret_cnt;
    logic [ADDR_W-1:0]   base;
    logic                restart_pend;
    logic                next_sel;
    logic [ADDR_W-1:0]   sel_base;
    logic [ADDR_W-1:0]   burst_off;
    logic                space_ok;

`ifdef FRAME_PINGPONG_EN
    frame_buf_sel u_buf_sel (
        .clk           (pixel_clk),
        .rst           (sys_rst),
        .frame_start   (frame_start),
        .wr_frame_done (wr_frame_done),
        .next_sel      (next_sel),
        .disp_buf_sel  (disp_buf_sel)
    );
`else
    logic unused_wr_frame_done;
    assign unused_wr_frame_done = wr_frame_done;
    assign next_sel             = 1'b0;
    assign disp_buf_sel         = 1'b0;
`endif

    // next_sel already reflects a swap taking effect on this cycle's frame_start.
    assign sel_base   = next_sel ? FB_BASE1 : FB_BASE0;
    assign burst_off  = ADDR_W'(burst_idx) * ADDR_W'(BURST_LEN);
    assign space_ok   = ({1'b0, fifo_level} + 12'(BURST_LEN)) <= 12'(FIFO_DEPTH);
    assign rd_cmd_len = 8'(BURST_LEN);

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            burst_idx    <= '0;
            ret_cnt      <= '0;
            base         <= '0;
            restart_pend <= 1'b0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_addr  <= '0;
            frame_active <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            if (rd_data_valid && state != WAIT_DATA) begin
                ovf_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        base         <= sel_base;
                        burst_idx    <= '0;
                        state        <= WAIT_SPACE;
                        frame_active <= 1'b1;
                    end
                end
                WAIT_SPACE: begin
                    if (frame_start) begin
                        base      <= sel_base;
                        burst_idx <= '0;
                    end else if (space_ok) begin
                        rd_cmd_valid <= 1'b1;
                        rd_cmd_addr  <= base + burst_off;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (frame_start) begin
                        restart_pend <= 1'b1;
                    end
                    if (rd_cmd_ready) begin
                        rd_cmd_valid <= 1'b0;
                        ret_cnt      <= '0;
                        state        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (rd_data_valid && ret_cnt == RET_W'(BURST_LEN - 1)) begin
                        if (restart_pend || frame_start) begin
                            restart_pend <= 1'b0;
                            burst_idx    <= '0;
                            base         <= sel_base;
                            state        <= WAIT_SPACE;
                        end else if (burst_idx == BIDX_W'(N_BURSTS - 1)) begin
                            state        <= IDLE;
                            frame_active <= 1'b0;
                        end else begin
                            burst_idx <= burst_idx + 1'b1;
                            state     <= WAIT_SPACE;
                        end
                    end else begin
                        if (rd_data_valid) begin
                            ret_cnt <= ret_cnt + 1'b1;
                        end
                        if (frame_start) begin
                            restart_pend <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
